ball_physics: RTL and testbench

- Parametrised frame-rate ball engine for pong_game; successor to the fixed-geometry ball mover.
- Runs on clk50M and advances once per frame_tick strobe instead of being clocked by the frame edge.
- Adds a serve/score state machine, signed multi-pixel velocity, paddle hit-zone deflection and speed-up after repeated hits.
- Feeds ball_graphics, score and fsm.

---
 rtl/pong_pkg.sv | 34 +++
 rtl/paddle_hit_zone.sv | 38 +++
 rtl/ball_physics.sv | 198 +++++++++++++++++++
 tb/tb_ball_physics.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong geometry, velocity type and ball state encoding.
// Used by ball_physics and its paddle hit-zone helper.
package pong_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BALL_SIZE    = 10;
  localparam int PADDLE_LEN   = 50;
  localparam int PADDLE_W     = 5;
  localparam int PADDLE_ONE_X = 30;
  localparam int PADDLE_TWO_X = 600;
  localparam int WALL_MARGIN  = 10;
  localparam int VEL_W        = 4;
  localparam int POS_W        = 10;
  localparam int COORD_W      = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_SCORED
  } state_t;

  typedef logic signed [VEL_W-1:0]   vel_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  function automatic vel_t vel_abs(input vel_t v);
    return v[VEL_W-1] ? -v : v;
  endfunction

  function automatic coord_t pos_to_coord(input logic [POS_W-1:0] p);
    return coord_t'({{(COORD_W-POS_W){1'b0}}, p});
  endfunction

endpackage

// File: rtl/paddle_hit_zone.sv
// Combinational paddle overlap test and hit-zone deflection of vy.
// Zero latency, no flow control.
module paddle_hit_zone
  import pong_pkg::*;
(
  input  logic [POS_W-1:0] paddle_y,
  input  coord_t           ny,
  input  vel_t             vy_in,
  output logic             overlap,
  output vel_t             vy_out
);

  localparam coord_t BALL_LAST  = coord_t'(BALL_SIZE - 1);
  localparam coord_t BALL_HALF  = coord_t'(BALL_SIZE / 2);
  localparam coord_t PAD_LAST   = coord_t'(PADDLE_LEN - 1);
  localparam coord_t ZONE_LOW   = coord_t'(PADDLE_LEN / 3);
  localparam coord_t ZONE_HIGH  = coord_t'((2 * PADDLE_LEN) / 3);
  localparam vel_t   VY_STEEP   = vel_t'(2);
  localparam vel_t   VY_SHALLOW = vel_t'(1);

  coord_t py;
  coord_t off;

  assign py  = pos_to_coord(paddle_y);
  assign off = ny + BALL_HALF - py;

  assign overlap = (ny + BALL_LAST >= py) && (ny <= py + PAD_LAST);

  always_comb begin
    vy_out = vy_in[VEL_W-1] ? -VY_SHALLOW : VY_SHALLOW;
    if (off < ZONE_LOW) begin
      vy_out = -VY_STEEP;
    end else if (off > ZONE_HIGH) begin
      vy_out = VY_STEEP;
    end
  end

endmodule

// File: rtl/ball_physics.sv
// Frame-tick ball engine: serve/score FSM, wall bounce, paddle deflection, speed-up; outputs registered one cycle after frame_tick.
// No backpressure: every frame_tick in PLAY is consumed.
module ball_physics
  import pong_pkg::*;
#(
  parameter int MAX_SPEED    = 4,
  parameter int SPEEDUP_HITS = 4
) (
  input  logic             clk50M,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             serve,
  input  logic             serve_dir,
  input  logic [POS_W-1:0] paddle_one_y,
  input  logic [POS_W-1:0] paddle_two_y,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic [1:0]       collided,
  output logic [1:0]       missed,
  output logic             in_play
);

  localparam int HIT_W = $clog2(SPEEDUP_HITS + 1);

  localparam logic [POS_W-1:0] CENTRE_X  = POS_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] CENTRE_Y  = POS_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] TOP_Y     = POS_W'(WALL_MARGIN);
  localparam logic [POS_W-1:0] BOTTOM_Y  = POS_W'(SCREEN_H - WALL_MARGIN - BALL_SIZE);
  localparam logic [POS_W-1:0] LEFT_X    = POS_W'(PADDLE_ONE_X + PADDLE_W + 1);
  localparam logic [POS_W-1:0] RIGHT_X   = POS_W'(PADDLE_TWO_X - BALL_SIZE);

  localparam coord_t BALL_LAST  = coord_t'(BALL_SIZE - 1);
  localparam coord_t TOP_WALL   = coord_t'(WALL_MARGIN);
  localparam coord_t BOT_WALL   = coord_t'(SCREEN_H - WALL_MARGIN);
  localparam coord_t LEFT_FACE  = coord_t'(PADDLE_ONE_X + PADDLE_W);
  localparam coord_t RIGHT_FACE = coord_t'(PADDLE_TWO_X);
  localparam coord_t RIGHT_EXIT = coord_t'(SCREEN_W - BALL_SIZE);
  localparam coord_t ZERO_C     = coord_t'(0);

  localparam vel_t VEL_ONE = vel_t'(1);
  localparam vel_t VEL_MAX = vel_t'(MAX_SPEED);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   x_q, x_d;
  logic [POS_W-1:0]   y_q, y_d;
  vel_t               vx_q, vx_d;
  vel_t               vy_q, vy_d;
  vel_t               speed_q, speed_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic [1:0]         collided_q, collided_d;
  logic [1:0]         missed_q, missed_d;

  coord_t             x_c, nx, ny;
  logic [POS_W-1:0]   y_wall;
  vel_t               vy_wall;
  logic               ov_one, ov_two;
  vel_t               vy_one, vy_two;
  logic               hit_one, hit_two;
  logic [HIT_W-1:0]   hits_inc;
  vel_t               speed_hit;
  logic               vx_neg, vx_pos;

  assign x_c    = pos_to_coord(x_q);
  assign nx     = x_c + coord_t'(vx_q);
  assign ny     = pos_to_coord(y_q) + coord_t'(vy_q);
  assign vx_neg = vx_q[VEL_W-1];
  assign vx_pos = !vx_q[VEL_W-1] && (vx_q != '0);

  // Vertical axis resolves first; paddle deflection then overrides vy on a hit.
  always_comb begin
    y_wall  = ny[POS_W-1:0];
    vy_wall = vy_q;
    if (ny <= TOP_WALL) begin
      y_wall  = TOP_Y;
      vy_wall = vel_abs(vy_q);
    end else if (ny + BALL_LAST >= BOT_WALL) begin
      y_wall  = BOTTOM_Y;
      vy_wall = -vel_abs(vy_q);
    end
  end

  paddle_hit_zone u_zone_one (
    .paddle_y (paddle_one_y),
    .ny       (ny),
    .vy_in    (vy_wall),
    .overlap  (ov_one),
    .vy_out   (vy_one)
  );

  paddle_hit_zone u_zone_two (
    .paddle_y (paddle_two_y),
    .ny       (ny),
    .vy_in    (vy_wall),
    .overlap  (ov_two),
    .vy_out   (vy_two)
  );

  // Crossing tests need the previous x so a fast ball cannot tunnel a paddle.
  assign hit_one = vx_neg && (nx <= LEFT_FACE) && (x_c > LEFT_FACE) && ov_one;
  assign hit_two = vx_pos && (nx + BALL_LAST >= RIGHT_FACE) &&
                   (x_c + BALL_LAST < RIGHT_FACE) && ov_two;

  always_comb begin
    hits_inc  = hits_q + HIT_W'(1);
    speed_hit = speed_q;
    if (hits_inc == HIT_W'(SPEEDUP_HITS)) begin
      speed_hit = (speed_q >= VEL_MAX) ? VEL_MAX : speed_q + VEL_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    speed_d    = speed_q;
    hits_d     = hits_q;
    collided_d = 2'b00;
    missed_d   = 2'b00;

    case (state_q)
      ST_IDLE, ST_SCORED: begin
        if (serve) begin
          state_d = ST_PLAY;
          x_d     = CENTRE_X;
          y_d     = CENTRE_Y;
          vx_d    = serve_dir ? -VEL_ONE : VEL_ONE;
          vy_d    = VEL_ONE;
          speed_d = VEL_ONE;
          hits_d  = '0;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          y_d  = y_wall;
          vy_d = vy_wall;
          if (hit_one || hit_two) begin
            speed_d = speed_hit;
            hits_d  = (hits_inc == HIT_W'(SPEEDUP_HITS)) ? '0 : hits_inc;
            if (hit_one) begin
              x_d           = LEFT_X;
              vx_d          = speed_hit;
              vy_d          = vy_one;
              collided_d[0] = 1'b1;
            end else begin
              x_d           = RIGHT_X;
              vx_d          = -speed_hit;
              vy_d          = vy_two;
              collided_d[1] = 1'b1;
            end
          end else if (nx <= ZERO_C || nx >= RIGHT_EXIT) begin
            missed_d = (nx <= ZERO_C) ? 2'b01 : 2'b10;
            state_d  = ST_SCORED;
            x_d      = CENTRE_X;
            y_d      = CENTRE_Y;
            vx_d     = '0;
            vy_d     = '0;
          end else begin
            x_d = nx[POS_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= CENTRE_X;
      y_q        <= CENTRE_Y;
      vx_q       <= '0;
      vy_q       <= '0;
      speed_q    <= VEL_ONE;
      hits_q     <= '0;
      collided_q <= 2'b00;
      missed_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      speed_q    <= speed_d;
      hits_q     <= hits_d;
      collided_q <= collided_d;
      missed_q   <= missed_d;
    end
  end

  assign ball_x   = x_q;
  assign ball_y   = y_q;
  assign collided = collided_q;
  assign missed   = missed_q;
  assign in_play  = (state_q == ST_PLAY);

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: serve, walls, paddle deflection, miss, speed-up, reset and serve/tick overlap.
module tb_ball_physics;

  logic       clk50M = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic       serve_dir = 1'b0;
  logic [9:0] paddle_one_y = '0;
  logic [9:0] paddle_two_y = '0;
  logic [9:0] ball_x, ball_y;
  logic [1:0] collided, missed;
  logic       in_play;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  ball_physics dut (
    .clk50M       (clk50M),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .serve        (serve),
    .serve_dir    (serve_dir),
    .paddle_one_y (paddle_one_y),
    .paddle_two_y (paddle_two_y),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .collided     (collided),
    .missed       (missed),
    .in_play      (in_play)
  );

  always #5 clk50M = ~clk50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk50M);
    reset = 1'b1;
    @(negedge clk50M);
    reset = 1'b0;
  endtask

  task automatic serve_pulse(input logic dir);
    @(negedge clk50M);
    serve = 1'b1;
    serve_dir = dir;
    @(negedge clk50M);
    serve = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk50M);
    frame_tick = 1'b1;
    @(negedge clk50M);
    frame_tick = 1'b0;
  endtask

  // Paddles follow the ball so every approach becomes a centre-zone hit.
  task automatic tick_track();
    logic [9:0] p;
    @(negedge clk50M);
    p = (ball_y >= 10'd20) ? ball_y - 10'd20 : 10'd0;
    paddle_one_y = p;
    paddle_two_y = p;
    frame_tick = 1'b1;
    @(negedge clk50M);
    frame_tick = 1'b0;
  endtask

  initial begin
    int hits;
    int ticks;
    int exp_speed;
    int disp;
    logic left_side;

    // Reset state
    do_reset();
    check("rst_x", 32'(ball_x), 315);
    check("rst_y", 32'(ball_y), 235);
    check("rst_in_play", 32'(in_play), 0);
    check("rst_collided", 32'(collided), 0);
    check("rst_missed", 32'(missed), 0);

    // Serve right, one tick
    serve_pulse(1'b0);
    check("serve_in_play", 32'(in_play), 1);
    check("serve_x", 32'(ball_x), 315);
    tick();
    check("t1_x", 32'(ball_x), 316);
    check("t1_y", 32'(ball_y), 236);
    check("t1_collided", 32'(collided), 0);
    check("t1_missed", 32'(missed), 0);

    // Serve left, bottom wall at tick 226, left paddle hit at tick 280
    do_reset();
    paddle_one_y = 10'd400;
    paddle_two_y = 10'd0;
    serve_pulse(1'b1);
    for (int t = 1; t <= 281; t++) begin
      tick();
      if (t == 226) check("wall_y226", 32'(ball_y), 460);
      if (t == 227) check("wall_y227", 32'(ball_y), 459);
      if (t == 279) check("pre_hit_collided", 32'(collided), 0);
      if (t == 280) begin
        check("hit_collided", 32'(collided), 32'b01);
        check("hit_x", 32'(ball_x), 36);
        check("hit_y", 32'(ball_y), 406);
      end
      if (t == 281) begin
        check("post_hit_collided", 32'(collided), 0);
        check("post_hit_x", 32'(ball_x), 37);
        check("post_hit_y", 32'(ball_y), 404);
      end
    end

    // Paddle out of reach: miss at tick 315, serve during PLAY ignored
    do_reset();
    paddle_one_y = 10'd0;
    serve_pulse(1'b1);
    for (int t = 1; t <= 316; t++) begin
      tick();
      if (t == 100) begin
        serve_pulse(1'b0);
        check("ign_serve_x", 32'(ball_x), 215);
        check("ign_serve_y", 32'(ball_y), 335);
        check("ign_serve_play", 32'(in_play), 1);
      end
      if (t == 280) begin
        check("nohit_collided", 32'(collided), 0);
        check("nohit_x", 32'(ball_x), 35);
      end
      if (t == 314) check("premiss_x", 32'(ball_x), 1);
      if (t == 315) begin
        check("miss_pulse", 32'(missed), 32'b01);
        check("miss_x", 32'(ball_x), 315);
        check("miss_y", 32'(ball_y), 235);
        check("miss_in_play", 32'(in_play), 0);
      end
      if (t == 316) begin
        check("scored_missed", 32'(missed), 0);
        check("scored_x", 32'(ball_x), 315);
      end
    end
    serve_pulse(1'b0);
    check("reserve_in_play", 32'(in_play), 1);

    // Rally: speed steps every 4 hits, capped at 4
    do_reset();
    serve_pulse(1'b1);
    hits = 0;
    ticks = 0;
    while (hits < 18 && ticks < 12000) begin
      tick_track();
      ticks++;
      if (missed != 2'b00) begin
        check("rally_missed", 32'(missed), 0);
        ticks = 12000;
      end else if (collided != 2'b00) begin
        hits++;
        left_side = collided[0];
        check($sformatf("rally_hit%0d_x", hits), 32'(ball_x), left_side ? 36 : 590);
        exp_speed = (1 + hits / 4 > 4) ? 4 : 1 + hits / 4;
        tick_track();
        ticks++;
        disp = left_side ? int'(ball_x) - 36 : 590 - int'(ball_x);
        check($sformatf("rally_hit%0d_speed", hits), 32'(disp), 32'(exp_speed));
      end
    end
    check("rally_hits", 32'(hits), 18);

    // Reset together with frame_tick mid-PLAY
    serve_pulse(1'b0);
    tick();
    tick();
    @(negedge clk50M);
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk50M);
    reset = 1'b0;
    frame_tick = 1'b0;
    check("midrst_in_play", 32'(in_play), 0);
    check("midrst_x", 32'(ball_x), 315);
    check("midrst_y", 32'(ball_y), 235);
    check("midrst_collided", 32'(collided), 0);
    check("midrst_missed", 32'(missed), 0);

    // Serve and frame_tick in the same cycle
    @(negedge clk50M);
    serve = 1'b1;
    serve_dir = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk50M);
    serve = 1'b0;
    frame_tick = 1'b0;
    check("st_same_x", 32'(ball_x), 315);
    check("st_same_y", 32'(ball_y), 235);
    check("st_same_play", 32'(in_play), 1);
    tick();
    check("st_next_x", 32'(ball_x), 316);
    check("st_next_y", 32'(ball_y), 236);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
